srsg_multi: RTL and testbench

Parametrised LFSR pattern generator for BIST test-pattern generation. It succeeds the fixed-width serial generator with several additions:
- true N-bit generality;
- selectable internal-XOR (Galois) or external-XOR (Fibonacci) feedback;
- parallel and serial outputs;
- a start/busy/done handshake with a programmable pattern count;
- all-zero lock-up detection and recovery.

It sits between the BIST controller, which issues start and counts, and the CUT input mux.

---
 rtl/srsg_multi.sv | 132 +++++++++++++
 tb/tb_srsg_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srsg_multi.sv
// Parametrised LFSR test-pattern generator with Galois/Fibonacci feedback,
// start/busy/done run control, programmable pattern count and zero-state recovery.
module srsg_multi #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     poly,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] num_patterns,
  output logic             busy,
  output logic             done,
  output logic             sout,
  output logic [N-1:0]     pout,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             lockup
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_STATE = {{(N-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_mode;
  logic [N-1:0]     r_poly;
  logic [CNT_W-1:0] r_num;
  logic [N-1:0]     r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lockup;
  logic             r_busy;
  logic             r_done;

  logic [N-1:0]     w_galois;
  logic [N-1:0]     w_fib;
  logic [N-1:0]     w_next;
  logic [N-1:0]     w_seed_safe;
  logic             w_last;

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_galois
      assign w_galois[gi] = r_lfsr[gi+1] ^ (r_lfsr[0] & r_poly[gi]);
    end
  endgenerate
  assign w_galois[N-1] = r_lfsr[0];

  assign w_fib       = {^(r_lfsr & r_poly), r_lfsr[N-1:1]};
  assign w_next      = r_mode ? w_fib : w_galois;
  assign w_seed_safe = (seed == '0) ? ONE_STATE : seed;
  assign w_last      = (r_cnt == r_num - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_poly   <= '0;
      r_num    <= '0;
      r_lfsr   <= ONE_STATE;
      r_cnt    <= '0;
      r_lockup <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      // Start wins over completion and advance in any state.
      r_mode   <= mode;
      r_poly   <= poly;
      r_num    <= num_patterns;
      r_lfsr   <= w_seed_safe;
      r_lockup <= (seed == '0);
      r_cnt    <= '0;
      if (num_patterns == '0) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        S_RUN: begin
          if (en) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              // A zero next state would stick forever; reseed instead.
              if (w_next == '0) begin
                r_lfsr   <= w_seed_safe;
                r_lockup <= 1'b1;
              end else begin
                r_lfsr <= w_next;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign pout    = r_lfsr;
  assign sout    = r_lfsr[0];
  assign pat_cnt = r_cnt;
  assign lockup  = r_lockup;

endmodule

// File: tb/tb_srsg_multi.sv
// Scoreboard bench for srsg_multi: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_srsg_multi;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start, en, mode;
  logic [N-1:0]  poly, seed;
  logic [CW-1:0] num_patterns;
  logic          busy, done, sout, lockup;
  logic [N-1:0]  pout;
  logic [CW-1:0] pat_cnt;

  srsg_multi #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .mode(mode),
    .poly(poly), .seed(seed), .num_patterns(num_patterns),
    .busy(busy), .done(done), .sout(sout), .pout(pout),
    .pat_cnt(pat_cnt), .lockup(lockup)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_done;
    logic [N-1:0]  pout;
    logic [CW-1:0] cnt;
    logic          lock;
  } exp_t;

  exp_t          exp_q[$];
  logic [N-1:0]  obs_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // Reference model state (phase: 0 idle, 1 run, 2 done)
  logic          m_mode;
  logic [N-1:0]  m_poly, m_lfsr;
  logic [CW-1:0] m_num, m_cnt;
  logic          m_lock;
  int            m_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Next state straight from the feedback equations using integer arithmetic.
  function automatic logic [N-1:0] spec_next(input logic md, input logic [N-1:0] p, input logic [N-1:0] d);
    int di, pi, r;
    di = int'(d);
    pi = int'(p);
    if (!md) begin
      r = di / 2;
      if (di % 2 == 1) r = r ^ ((pi % (1 << (N-1))) + (1 << (N-1)));
    end else begin
      r = (di / 2) + (($countones(d & p) % 2) * (1 << (N-1)));
    end
    return r[N-1:0];
  endfunction

  task automatic push_state();
    exp_t e;
    e.is_done = (m_phase == 2);
    e.pout    = m_lfsr;
    e.cnt     = m_cnt;
    e.lock    = m_lock;
    if (m_phase != 0) exp_q.push_back(e);
  endtask

  task automatic finish_done();
    @(posedge clk); #1;
    m_phase = 0;
  endtask

  task automatic kick(input logic md, input logic [N-1:0] p, input logic [N-1:0] s, input logic [CW-1:0] n);
    start = 1'b1; mode = md; poly = p; seed = s; num_patterns = n;
    m_mode = md; m_poly = p; m_num = n; m_cnt = '0;
    m_lfsr = (s == '0) ? N'(1) : s;
    m_lock = (s == '0);
    m_phase = (n == '0) ? 2 : 1;
    @(posedge clk); #1;
    start = 1'b0;
    push_state();
    if (m_phase == 2) finish_done();
  endtask

  task automatic step(input logic e, input logic scramble);
    logic [N-1:0] nx;
    en = e;
    if (scramble) begin
      mode = 1'($urandom); poly = N'($urandom);
      seed = N'($urandom); num_patterns = CW'($urandom);
    end
    if (e) begin
      if (32'(m_cnt) == 32'(m_num) - 1) begin
        m_phase = 2;
      end else begin
        nx = spec_next(m_mode, m_poly, m_lfsr);
        if (nx == '0) begin
          m_lfsr = (seed == '0) ? N'(1) : seed;
          m_lock = 1'b1;
        end else begin
          m_lfsr = nx;
        end
        m_cnt = m_cnt + 1'b1;
      end
    end
    @(posedge clk); #1;
    push_state();
    if (m_phase == 2) finish_done();
  endtask

  task automatic run_out(input int pct_en, input logic scramble);
    int guard = 0;
    while (m_phase == 1 && guard < 1000) begin
      step(($urandom_range(99) < pct_en) ? 1'b1 : 1'b0, scramble);
      guard++;
    end
    check("run_terminates", (guard < 1000) ? 1 : 0, 1);
  endtask

  task automatic check_seq(input string name, input int vals[], input int len);
    check({name, "_len"}, obs_q.size(), len);
    for (int i = 0; i < len && i < obs_q.size(); i++) check(name, obs_q[i], vals[i]);
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, busy, done}, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy", busy, !e.is_done);
          check("done", done, e.is_done);
          check("pout", pout, e.pout);
          check("pat_cnt", pat_cnt, e.cnt);
          check("lockup", lockup, e.lock);
          check("sout", sout, e.pout[0]);
          if (busy) obs_q.push_back(pout);
        end
      end else if (exp_q.size() != 0) begin
        check("missing_output", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int gal[] = '{8, 4, 2, 1, 11, 14};
    int fib[] = '{8, 4, 2, 9, 12, 6};
    int lck[] = '{1, 1, 1};
    start = 0; en = 0; mode = 0; poly = '0; seed = '0; num_patterns = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_pout", pout, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lockup", lockup, 0);
    check("rst_cnt", pat_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    obs_q.delete(); kick(0, 4'b0011, 4'b1000, 6); run_out(100, 0);
    check_seq("galois_seq", gal, 6);
    check("galois_end_pout", pout, 14);
    check("galois_end_busy", busy, 0);

    obs_q.delete(); kick(1, 4'b0011, 4'b1000, 6); run_out(100, 0);
    check_seq("fib_seq", fib, 6);

    obs_q.delete(); kick(1, 4'b0010, 4'b0001, 3); run_out(100, 0);
    check_seq("lockup_seq", lck, 3);
    check("lockup_sticky", lockup, 1);

    obs_q.delete(); kick(0, 4'b0011, 4'b0000, 2);
    check("zero_seed_pout", pout, 1);
    check("zero_seed_lockup", lockup, 1);
    run_out(100, 0);

    obs_q.delete(); kick(0, 4'b0011, 4'b1000, 6);
    for (int i = 0; i < 40 && m_phase == 1; i++) step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
    check("stall_busy_cycles", obs_q.size(), 11);

    kick(0, 4'b0011, 4'b1000, 4);
    repeat (3) step(1'b1, 1'b0);
    kick(1, 4'b0011, 4'b0101, 2);
    check("restart_pout", pout, 5);
    check("restart_cnt", pat_cnt, 0);
    check("restart_done", done, 0);
    run_out(100, 0);

    obs_q.delete(); kick(0, 4'b0011, 4'b1000, 0);
    check("zero_count_busy_cycles", obs_q.size(), 0);

    kick(0, 4'b0011, 4'b1000, 10);
    repeat (3) step(1'b1, 1'b0);
    #2 rst = 1'b0;
    exp_q.delete(); m_phase = 0; en = 1'b0;
    #1;
    check("arst_pout", pout, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_lockup", lockup, 0);
    check("arst_cnt", pat_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_pout", pout, 1);

    for (int r = 0; r < 40; r++) begin
      kick(1'($urandom), N'($urandom), N'($urandom), CW'($urandom_range(0, 9)));
      if (m_phase == 1 && $urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 4)) if (m_phase == 1) step(1'($urandom), 1'b1);
        kick(1'($urandom), N'($urandom), N'($urandom), CW'($urandom_range(0, 9)));
      end
      run_out($urandom_range(30, 100), 1'b1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
